exhaustive_equiv_checker: RTL and testbench

//   Self-checking on-chip successor to the bench-level truth-table sweep. Drives an N-bit input vector through
//   all 2^WIDTH values and compares NCH parallel implementations of one Boolean function.

---
 rtl/exhaustive_equiv_checker_pkg.sv | 29 ++
 rtl/exhaustive_equiv_checker_vector_sweeper.sv | 44 ++++
 rtl/exhaustive_equiv_checker.sv | 137 +++++++++++++
 tb/tb_exhaustive_equiv_checker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exhaustive_equiv_checker_pkg.sv
// Shared definitions for the exhaustive equivalence checker: state encodings
// and the counter-width helper.
package eqchk_defs;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_CHECK  = ST_CHECK,
        S_DONE   = ST_DONE
    } state_t;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/exhaustive_equiv_checker_vector_sweeper.sv
// Vector counter plus per-vector settle timer; reports when the current vector
// may be sampled and whether it is the final (all-ones) vector.
module vector_sweeper
    import eqchk_defs::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_tick,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_bits,
    output logic             o_sample_now,
    output logic             o_last_vec
);
    localparam int unsigned CW = clog2(SETTLE + 1);
    // SETTLE wait cycles precede the sampling cycle, so the timer reloads with SETTLE-1.
    localparam logic [CW-1:0] RELOAD = CW'((SETTLE == 0) ? 0 : SETTLE - 1);

    logic [WIDTH-1:0] r_bits;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bits <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_bits <= '0;
            r_cnt  <= RELOAD;
        end else if (i_step) begin
            r_bits <= r_bits + WIDTH'(1);
            r_cnt  <= RELOAD;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    assign o_bits       = r_bits;
    assign o_sample_now = (r_cnt == '0);
    assign o_last_vec   = &r_bits;

endmodule

// File: rtl/exhaustive_equiv_checker.sv
// Sweeps every input vector, compares channels 1..NCH-1 against golden
// channel 0 and accumulates the verdict, mismatch count, mask and first failure.
module exhaustive_equiv_checker
    import eqchk_defs::*;
#(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned NCH    = 5,
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] bits,
    input  logic [NCH-1:0]   dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   mismatch_count,
    output logic [NCH-1:0]   fail_mask,
    output logic             first_fail_vld,
    output logic [WIDTH-1:0] first_fail_vec
);
    localparam int unsigned CNT_W  = WIDTH + 1;
    localparam state_t      RUN_ST = (SETTLE == 0) ? S_CHECK : S_SETTLE;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_count;
    logic [NCH-1:0]   r_mask;
    logic             r_ffv;
    logic [WIDTH-1:0] r_ffvec;

    logic             w_start_ok;
    logic             w_abort;
    logic             w_tick;
    logic             w_check;
    logic             w_step;
    logic             w_sample_now;
    logic             w_last_vec;
    logic [WIDTH-1:0] w_bits;
    logic [NCH-1:0]   w_miss;
    logic             w_miss_any;
    logic [CNT_W-1:0] w_count_nxt;

    // Abort outranks start and suppresses the compare in the same cycle.
    assign w_abort     = abort && (r_state != S_IDLE);
    assign w_start_ok  = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_tick      = !abort && (r_state == S_SETTLE);
    assign w_check     = !abort && (r_state == S_CHECK);
    assign w_step      = w_check && !w_last_vec;
    assign w_miss      = dut_out ^ {NCH{dut_out[0]}};
    assign w_miss_any  = |w_miss;
    assign w_count_nxt = r_count + CNT_W'(w_miss_any);

    vector_sweeper #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_sweeper (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_start_ok),
        .i_tick       (w_tick),
        .i_step       (w_step),
        .o_bits       (w_bits),
        .o_sample_now (w_sample_now),
        .o_last_vec   (w_last_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_count <= '0;
            r_mask  <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (w_start_ok) begin
            r_state <= RUN_ST;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_count <= '0;
            r_mask  <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else begin
            case (r_state)
                S_SETTLE: begin
                    if (w_sample_now) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_miss_any) begin
                        r_count <= w_count_nxt;
                        r_mask  <= r_mask | w_miss;
                        if (!r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= w_bits;
                        end
                    end
                    if (w_last_vec) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_count_nxt == '0);
                    end else begin
                        r_state <= RUN_ST;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign bits           = w_bits;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign mismatch_count = r_count;
    assign fail_mask      = r_mask;
    assign first_fail_vld = r_ffv;
    assign first_fail_vec = r_ffvec;

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
// Bench for exhaustive_equiv_checker: two instances (SETTLE=0 and SETTLE=2)
// fed by randomized truth tables with planned per-vector channel faults.
module tb_exhaustive_equiv_checker;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       start0, abort0, busy0, done0, pass0, ffv0;
    logic [2:0] bits0, ffvec0;
    logic [4:0] dout0, mask0;
    logic [3:0] cnt0;

    logic       start2, abort2, busy2, done2, pass2, ffv2;
    logic [2:0] bits2, ffvec2;
    logic [4:0] dout2, mask2;
    logic [3:0] cnt2;

    logic [7:0] tt0, tt2;
    logic [4:0] flt0 [8];
    logic [4:0] flt2 [8];
    logic [4:0] glitch2;

    int n_cmp = 0;
    int n_err = 0;

    logic [14:0] res0, res2;
    assign res0 = {done0, pass0, cnt0, mask0, ffv0, ffvec0};
    assign res2 = {done2, pass2, cnt2, mask2, ffv2, ffvec2};

    always_comb dout0 = {5{tt0[bits0]}} ^ flt0[bits0];
    always_comb dout2 = {5{tt2[bits2]}} ^ flt2[bits2] ^ glitch2;

    exhaustive_equiv_checker #(.WIDTH(3), .NCH(5), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .bits(bits0),
        .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
        .mismatch_count(cnt0), .fail_mask(mask0),
        .first_fail_vld(ffv0), .first_fail_vec(ffvec0));

    exhaustive_equiv_checker #(.WIDTH(3), .NCH(5), .SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .bits(bits2),
        .dut_out(dout2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_count(cnt2), .fail_mask(mask2),
        .first_fail_vld(ffv2), .first_fail_vec(ffvec2));

    // Reference: evaluate each channel per vector, compare to channel 0, tally.
    task automatic model0(input int upto, input logic fin, output logic [14:0] exp);
        int         cnt;
        logic [4:0] mask;
        logic       ffv, any, o0, oi;
        logic [2:0] ffvec;
        cnt = 0; mask = '0; ffv = 1'b0; ffvec = '0;
        for (int v = 0; v < upto; v++) begin
            any = 1'b0;
            o0  = tt0[v] ^ flt0[v][0];
            for (int i = 1; i < 5; i++) begin
                oi = tt0[v] ^ flt0[v][i];
                if (oi != o0) begin
                    any     = 1'b1;
                    mask[i] = 1'b1;
                end
            end
            if (any) begin
                cnt++;
                if (!ffv) begin
                    ffv   = 1'b1;
                    ffvec = 3'(v);
                end
            end
        end
        exp = {fin, fin && (cnt == 0), 4'(cnt), mask, ffv, ffvec};
    endtask

    task automatic clear_faults0();
        for (int v = 0; v < 8; v++) flt0[v] = '0;
    endtask

    task automatic start_dut0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_bits0(input logic [2:0] target);
        for (int k = 0; k < 20 && bits0 !== target; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 0; abort0 = 0; start2 = 0; abort2 = 0; glitch2 = '0;
        tt0 = '0; tt2 = '0; clear_faults0();
        for (int v = 0; v < 8; v++) flt2[v] = '0;
        #12;
        n_cmp++;
        if ({res0, bits0, busy0} !== '0 || {res2, bits2, busy2} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got %h/%h exp 0", {res0, bits0, busy0}, {res2, bits2, busy2});
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({res0, bits0, busy0} !== '0) begin
            n_err++;
            $display("FAIL reset_release: got %h exp 0", {res0, bits0, busy0});
        end
    endtask

    task automatic test_clean_sweep();
        tt0 = 8'($urandom); clear_faults0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (bits0 !== 3'(i) || busy0 !== 1'b1 || done0 !== 1'b0) begin
                n_err++;
                $display("FAIL clean_seq: got bits=%0d busy=%b done=%b exp bits=%0d busy=1 done=0",
                         bits0, busy0, done0, i);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (res0 !== {1'b1, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0} || busy0 !== 1'b0 || bits0 !== 3'd7) begin
            n_err++;
            $display("FAIL clean_result: got res=%h busy=%b bits=%0d exp res=%h busy=0 bits=7",
                     res0, busy0, bits0, {1'b1, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0});
        end
    endtask

    task automatic test_single_fault();
        int          cyc;
        logic [14:0] exp;
        tt0 = 8'($urandom); clear_faults0(); flt0[5] = 5'b01000;
        start_dut0(); wait_done0(cyc);
        n_cmp++;
        if (cyc != 8) begin
            n_err++; $display("FAIL single_latency: got %0d exp 8", cyc);
        end
        exp = {1'b1, 1'b0, 4'd1, 5'b01000, 1'b1, 3'd5};
        n_cmp++;
        if (res0 !== exp) begin
            n_err++; $display("FAIL single_result: got %h exp %h", res0, exp);
        end
    endtask

    task automatic test_multi_fault();
        int          cyc;
        logic [14:0] exp;
        tt0 = 8'($urandom);
        for (int v = 0; v < 8; v++) flt0[v] = 5'b00010;
        flt0[2] = 5'b10010; flt0[6] = 5'b10010;
        start_dut0(); wait_done0(cyc);
        exp = {1'b1, 1'b0, 4'd8, 5'b10010, 1'b1, 3'd0};
        n_cmp++;
        if (res0 !== exp || cyc != 8) begin
            n_err++; $display("FAIL multi_result: got %h cyc=%0d exp %h cyc=8", res0, cyc, exp);
        end
    endtask

    task automatic test_random_back_to_back();
        int          cyc;
        logic [14:0] exp;
        for (int it = 0; it < 8; it++) begin
            tt0 = 8'($urandom);
            for (int v = 0; v < 8; v++)
                flt0[v] = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            model0(8, 1'b1, exp);
            start_dut0(); wait_done0(cyc);
            n_cmp++;
            if (res0 !== exp || cyc != 8) begin
                n_err++; $display("FAIL rand_run%0d: got %h cyc=%0d exp %h cyc=8", it, res0, cyc, exp);
            end
        end
    endtask

    task automatic test_settle();
        tt2 = 8'($urandom);
        for (int v = 0; v < 8; v++) flt2[v] = '0;
        flt2[6] = 5'b00010; glitch2 = '0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            glitch2 = (c == 9) ? 5'b00100 : 5'b00000;
            n_cmp++;
            if (bits2 !== 3'(c / 3) || done2 !== 1'b0 || busy2 !== 1'b1) begin
                n_err++;
                $display("FAIL settle_seq c=%0d: got bits=%0d done=%b busy=%b exp bits=%0d done=0 busy=1",
                         c, bits2, done2, busy2, c / 3);
            end
        end
        @(negedge clk); glitch2 = '0;
        n_cmp++;
        if (res2 !== {1'b1, 1'b0, 4'd1, 5'b00010, 1'b1, 3'd6}) begin
            n_err++;
            $display("FAIL settle_result: got %h exp %h", res2, {1'b1, 1'b0, 4'd1, 5'b00010, 1'b1, 3'd6});
        end
    endtask

    task automatic test_start_abort();
        logic [14:0] exp;
        tt0 = 8'($urandom);
        for (int v = 0; v < 8; v++) flt0[v] = 5'($urandom) | 5'b00001;
        model0(4, 1'b0, exp);
        start_dut0();
        wait_bits0(3'd3);
        start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        n_cmp++;
        if (bits0 !== 3'd4 || busy0 !== 1'b1) begin
            n_err++; $display("FAIL start_ignored: got bits=%0d busy=%b exp bits=4 busy=1", bits0, busy0);
        end
        abort0 = 1'b1;
        @(negedge clk); abort0 = 1'b0;
        n_cmp++;
        if (busy0 !== 1'b0 || res0 !== exp || bits0 !== 3'd4) begin
            n_err++;
            $display("FAIL abort_state: got busy=%b res=%h bits=%0d exp busy=0 res=%h bits=4",
                     busy0, res0, bits0, exp);
        end
        repeat (3) @(negedge clk);
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || res0 !== exp || bits0 !== 3'd4) begin
            n_err++;
            $display("FAIL abort_hold: got busy=%b res=%h bits=%0d exp busy=0 res=%h bits=4",
                     busy0, res0, bits0, exp);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        tt0 = 8'($urandom); clear_faults0();
        flt0[1] = 5'b00100; flt0[4] = 5'b01000;
        start_dut0();
        wait_bits0(3'd6);
        n_cmp++;
        if (bits0 !== 3'd6 || ffv0 !== 1'b1 || cnt0 !== 4'd2) begin
            n_err++; $display("FAIL prereset_state: got bits=%0d ffv=%b cnt=%0d exp 6/1/2", bits0, ffv0, cnt0);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({res0, bits0, busy0} !== '0) begin
            n_err++; $display("FAIL async_reset: got %h exp 0", {res0, bits0, busy0});
        end
        @(negedge clk); rst = 1'b0;
        clear_faults0();
        start_dut0(); wait_done0(cyc);
        n_cmp++;
        if (res0 !== {1'b1, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0} || cyc != 8) begin
            n_err++;
            $display("FAIL post_reset_run: got %h cyc=%0d exp %h cyc=8",
                     res0, cyc, {1'b1, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0});
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_multi_fault();
        test_random_back_to_back();
        test_settle();
        test_start_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
